// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 32x32 register file: round-robin between the ALU (A)
// and load-unit (B) writeback streams, plus a zeroing sweep that takes over the port.
module regfile_write_scheduler #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wbdata
);

  typedef enum logic {RUN, CLEAR} state_t;

  // One extra counter bit keeps DEPTH == 2^AW from wrapping before the last compare.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;   // 1 = B was granted last
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wbdata_q, wbdata_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;

  logic          grant_b, run, xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  always_comb begin
    grant_b  = b_valid & (~a_valid | ~last_grant_q);
    run      = reset & (state_q == RUN);
    a_ready  = run & a_valid & ~grant_b;
    b_ready  = run & grant_b;
    xfer     = a_ready | b_ready;
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wbdata_d     = wbdata_q;
    clr_done_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (xfer) begin
          // x0 is hard-wired zero: accept the request but suppress the write.
          we_d         = (sel_addr != '0);
          waddr_d      = sel_addr;
          wbdata_d     = sel_data;
          last_grant_d = grant_b;
        end
        if (clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        we_d     = 1'b1;
        waddr_d  = cnt_q[AW-1:0];
        wbdata_d = '0;
        if (cnt_q == CNT_LAST) begin
          state_d    = RUN;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    clr_busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wbdata_q     <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wbdata_q     <= wbdata_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wbdata   = wbdata_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a behavioural register file
// that registers its write inputs once more before the array.
module tb_regfile_write_scheduler;
  localparam int AW = 5, DW = 32, DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, waddr;
  logic [DW-1:0] a_data, b_data, wbdata;
  logic          clr_start, clr_busy, clr_done, we;

  int n_tot = 0;
  int n_bad = 0;

  regfile_write_scheduler #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .we(we), .waddr(waddr), .wbdata(wbdata)
  );

  always #5 clk = ~clk;

  // register file model: input stage then array, x0 reads zero
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    rf_we   <= we;
    rf_addr <= waddr;
    rf_data <= wbdata;
    if (rf_we && rf_addr != '0) mem[rf_addr] <= rf_data;
  end

  function automatic logic [DW-1:0] rd(input int a);
    return (a == 0) ? '0 : mem[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int ai, bi, busy_n, rdy_n, wr_ok, done_n, seen;
  logic          got_a, got_b;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  initial begin
    reset = 1'b0; clr_start = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;

    // reset held two edges with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_busy", clr_busy, 0);
      chk("rst_done", clr_done, 0);
    end
    reset = 1'b1;

    // contention: strict alternation starting with A, every request taken once
    ai = 0; bi = 0;
    for (int i = 0; i < 8; i++) begin
      a_valid = (ai < 4); a_addr = AW'(1 + ai);  a_data = 32'hA000_0000 | (1 + ai);
      b_valid = (bi < 4); b_addr = AW'(11 + bi); b_data = 32'hB000_0000 | (11 + bi);
      #1;
      chk("cont_a_ready", a_ready, (i % 2 == 0));
      chk("cont_b_ready", b_ready, (i % 2 == 1));
      got_a = a_ready; got_b = b_ready;
      exp_addr = (i % 2 == 0) ? AW'(1 + ai) : AW'(11 + bi);
      exp_data = (i % 2 == 0) ? (32'hA000_0000 | (1 + ai)) : (32'hB000_0000 | (11 + bi));
      tick;
      chk("cont_we", we, 1);
      chk("cont_waddr", waddr, exp_addr);
      chk("cont_wbdata", wbdata, exp_data);
      if (got_a) ai++;
      if (got_b) bi++;
    end
    chk("cont_a_count", ai, 4);
    chk("cont_b_count", bi, 4);
    a_valid = 1'b0; b_valid = 1'b0;

    // single requester A
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    chk("single_a_ready", a_ready, 1);
    chk("single_b_ready", b_ready, 0);
    tick;
    a_valid = 1'b0;
    chk("single_we", we, 1);
    chk("single_waddr", waddr, 5);
    chk("single_wbdata", wbdata, 32'hDEAD_BEEF);
    tick;
    chk("idle_we", we, 0);
    chk("idle_waddr_hold", waddr, 5);
    tick;
    chk("single_rd5", rd(5), 32'hDEAD_BEEF);

    // write to x0 is accepted but dropped
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234_5678;
    #1;
    chk("x0_b_ready", b_ready, 1);
    tick;
    b_valid = 1'b0;
    chk("x0_we", we, 0);
    tick; tick;
    chk("x0_rd0", rd(0), 0);

    // preload addr 7, then clear with A waiting on addr 9
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAA;
    tick;
    a_valid = 1'b0;
    chk("pre7_we", we, 1);
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    chk("clr_busy_start", clr_busy, 1);
    busy_n = 0; rdy_n = 0; wr_ok = 0; done_n = 0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      if (clr_busy) busy_n++;
      if (a_ready || b_ready) rdy_n++;
      if (clr_done) done_n++;
      clr_start = (k == 5);  // ignored while sweeping
      tick;
      clr_start = 1'b0;
      if (we && waddr == AW'(k) && wbdata == '0) wr_ok++;
    end
    chk("clr_busy_cycles", busy_n, DEPTH);
    chk("clr_ready_seen", rdy_n, 0);
    chk("clr_writes", wr_ok, DEPTH);
    chk("clr_done_early", done_n, 0);
    chk("clr_done_pulse", clr_done, 1);
    chk("clr_busy_end", clr_busy, 0);
    #1;
    chk("post_clr_a_ready", a_ready, 1);
    tick;
    a_valid = 1'b0;
    chk("post_clr_done_off", clr_done, 0);
    chk("post_clr_waddr", waddr, 9);
    chk("post_clr_we", we, 1);
    tick; tick;
    chk("post_clr_rd7", rd(7), 0);
    chk("post_clr_rd9", rd(9), 32'h99);
    chk("post_clr_rd31", rd(31), 0);

    // reset in the middle of a sweep
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    for (int k = 0; k < 10; k++) tick;
    chk("mid_clr_waddr", waddr, 9);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_done", clr_done, 0);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    #1;
    chk("mid_rst_run_ready", a_ready, 1);
    tick;
    a_valid = 1'b0;
    chk("mid_rst_no_done", clr_done, 0);
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    tick;
    chk("reclr_first_we", we, 1);
    chk("reclr_first_addr", waddr, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (clr_done) begin
        seen = 1;
        break;
      end
    end
    chk("reclr_done_seen", seen, 1);
    chk("reclr_last_addr", waddr, DEPTH - 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
